// File: rtl/cpu_bus_periph_v2.sv
// CPU native-bus decoder: RAM window passthrough plus a peripheral page with
// GPIO, button edge capture and an NCH-channel audio frame path.
module cpu_bus_periph_v2 #(
  parameter logic [31:0] RAM_BASE = 32'h0001_0000,
  parameter int          RAM_AW   = 15,
  parameter int          DIP_W    = 8,
  parameter int          LED_W    = 8,
  parameter int          BTN_W    = 5,
  parameter int          NCH      = 2,
  parameter int          SAMPLE_W = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  input  logic [3:0]                wstrb,
  input  logic                      valid,
  output logic                      ready,
  output logic [31:0]               rdata,
  input  logic [DIP_W-1:0]          dip,
  input  logic [BTN_W-1:0]          buttons,
  output logic [LED_W-1:0]          led,
  output logic [RAM_AW-1:0]         ram_addr,
  output logic [31:0]               ram_wdata,
  output logic [3:0]                ram_wstrb,
  output logic                      ram_valid,
  input  logic [31:0]               ram_rdata,
  input  logic                      ram_ready,
  output logic [NCH*SAMPLE_W-1:0]   audio_data,
  output logic                      audio_valid,
  input  logic                      audio_ready,
  input  logic                      audio_init_done
);

  // Handshakes: a CPU request completes on a cycle where valid && ready
  // (ready is combinational); an audio frame transfers on audio_valid &&
  // audio_ready, and audio_data is held stable until that cycle.

  localparam int          FW          = NCH * SAMPLE_W;
  localparam int          STG_N       = (NCH > 1) ? NCH - 1 : 1;
  localparam logic [23:0] PERIPH_PAGE = 24'h80_0000;
  localparam logic [5:0]  CH_BASE     = 6'd16;

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  s);
    return (old_v & ~lane_mask(s)) | (new_v & lane_mask(s));
  endfunction

  logic                ram_hit, periph_hit, is_ch, is_last, is_write;
  logic                can_commit, stall_blk, wr, commit, drop;
  logic [5:0]          word_idx;
  logic [2:0]          ch_idx;
  logic [DIP_W-1:0]    dip_s1, dip_s2;
  logic [BTN_W-1:0]    btn_s1, btn_s2, btn_prev, btn_edge, btn_clr;
  logic                ctrl_stall;
  logic [15:0]         drops;
  logic [SAMPLE_W-1:0] staging [STG_N];
  logic [FW-1:0]       frame_next;

  assign ram_hit    = (addr[31:RAM_AW] == RAM_BASE[31:RAM_AW]);
  assign periph_hit = !ram_hit && (addr[31:8] == PERIPH_PAGE);
  assign word_idx   = addr[7:2];
  assign ch_idx     = word_idx[2:0];
  assign is_ch      = periph_hit && (word_idx >= CH_BASE) && (word_idx < CH_BASE + 6'(NCH));
  assign is_last    = is_ch && (ch_idx == 3'(NCH - 1));
  assign is_write   = valid && (wstrb != 4'b0000);

  // A frame can be committed when the output slot is empty or drains this cycle.
  assign can_commit = !audio_valid || audio_ready;
  assign stall_blk  = is_write && is_last && !can_commit && ctrl_stall;
  assign ready      = ram_hit ? ram_ready : !stall_blk;
  assign wr         = is_write && periph_hit && !stall_blk;
  assign commit     = wr && is_last && can_commit;
  assign drop       = wr && is_last && !can_commit;

  assign ram_addr  = addr[RAM_AW-1:0];
  assign ram_wdata = wdata;
  assign ram_wstrb = wstrb;
  assign ram_valid = valid && ram_hit;

  assign btn_clr = (wr && word_idx == 6'd3) ? BTN_W'(wdata & lane_mask(wstrb)) : '0;

  always_comb begin
    frame_next = audio_data;
    for (int k = 0; k < NCH - 1; k++) frame_next[k*SAMPLE_W +: SAMPLE_W] = staging[k];
    frame_next[(NCH-1)*SAMPLE_W +: SAMPLE_W] =
      SAMPLE_W'(merge(32'(audio_data[(NCH-1)*SAMPLE_W +: SAMPLE_W]), wdata, wstrb));
  end

  always_comb begin
    rdata = 32'b0;
    if (ram_hit) begin
      rdata = ram_rdata;
    end else if (periph_hit) begin
      case (word_idx)
        6'd0:    rdata = 32'(dip_s2);
        6'd1:    rdata = 32'(led);
        6'd2:    rdata = 32'(btn_s2);
        6'd3:    rdata = 32'(btn_edge);
        6'd4:    rdata = {29'b0, audio_valid, audio_init_done, !audio_ready};
        6'd5:    rdata = {31'b0, ctrl_stall};
        6'd6:    rdata = {16'b0, drops};
        default: rdata = 32'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dip_s1      <= '0;
      dip_s2      <= '0;
      btn_s1      <= '0;
      btn_s2      <= '0;
      btn_prev    <= '0;
      btn_edge    <= '0;
      led         <= '0;
      ctrl_stall  <= 1'b1;
      drops       <= '0;
      audio_data  <= '0;
      audio_valid <= 1'b0;
      for (int k = 0; k < STG_N; k++) staging[k] <= '0;
    end else begin
      dip_s1   <= dip;
      dip_s2   <= dip_s1;
      btn_s1   <= buttons;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
      // A new edge wins over a coincident write-1-to-clear.
      btn_edge <= (btn_edge & ~btn_clr) | (btn_s2 & ~btn_prev);
      if (wr && word_idx == 6'd1) led <= LED_W'(merge(32'(led), wdata, wstrb));
      if (wr && word_idx == 6'd5 && wstrb[0]) ctrl_stall <= wdata[0];
      if (wr && word_idx == 6'd6) drops <= '0;
      else if (drop && drops != 16'hFFFF) drops <= drops + 16'd1;
      for (int k = 0; k < STG_N; k++) begin
        if (wr && is_ch && !is_last && ch_idx == 3'(k))
          staging[k] <= SAMPLE_W'(merge(32'(staging[k]), wdata, wstrb));
      end
      if (commit) begin
        audio_data  <= frame_next;
        audio_valid <= 1'b1;
      end else if (audio_ready) begin
        audio_valid <= 1'b0;
      end
    end
  end

endmodule
